// File: rtl/mips_defs_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   - Default address map constants (reset PC, exception vector, text window).
//   - Fetch state encoding and the buffered fetch entry layout.
//   - Helper that classifies a fetch address as an address-error fault.
package mips_defs;

  localparam int          WORD_W         = 32;
  localparam logic [31:0] MIPS_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] MIPS_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] MIPS_TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] MIPS_TEXT_HI    = 32'h0000_5000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;

  // Misaligned or outside [lo, hi) is an AdEL on fetch.
  function automatic logic addr_is_fault(input logic [31:0] a,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (a[1:0] != 2'b00) || (a < lo) || (a >= hi);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {err, pc, inst} entries.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_entry (ignored when full unless popping too)
//   i_entry      : entry to write
//   i_pop        : consume the head entry (ignored when empty)
//   i_flush      : empty the FIFO; overrides push and pop in the same cycle
//   o_valid      : head slot holds a live entry
//   o_full       : occupancy equals DEPTH
//   o_head       : head entry
module fetch_fifo
  import mips_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_valid,
  output logic         o_full,
  output fetch_entry_t o_head
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == CNT_FULL);
  assign w_do_pop  = i_pop && o_valid;
  // A full FIFO can still accept a write when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd];

  // Storage is reset too so head outputs are never X out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: owns the PC, reads the combinational instruction
// ROM, buffers {pc, inst} pairs and delivers them to decode over valid/ready.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   IM_addr / IR          : ROM address (= PC) and same-cycle read data
//   redirect_valid/_pc    : branch/jump redirect
//   exc_req               : exception entry to EXC_VECTOR
//   eret_req / epc        : return from exception to epc
//   inst_valid/inst_ready : decode handshake
//   inst_out, pc_out      : head instruction and its PC
//   fetch_err             : head entry is an address-error fault (inst_out=0)
module if_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC   = MIPS_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = MIPS_EXC_VECTOR,
  parameter logic [31:0] TEXT_LO    = MIPS_TEXT_LO,
  parameter logic [31:0] TEXT_HI    = MIPS_TEXT_HI,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] IM_addr,
  input  logic [31:0] IR,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        fetch_err
);

  logic [31:0]  r_pc;
  fetch_state_t r_state;
  logic [31:0]  w_pc_nxt;
  fetch_state_t w_state_nxt;
  logic         w_flush;
  logic         w_fault;
  logic         w_pop;
  logic         w_push;
  logic         w_valid;
  logic         w_full;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  assign IM_addr = r_pc;
  assign w_flush = exc_req || eret_req || redirect_valid;
  assign w_fault = addr_is_fault(r_pc, TEXT_LO, TEXT_HI);
  assign w_pop   = w_valid && inst_ready;
  assign w_push  = (r_state == ST_RUN) && !w_flush && (!w_full || w_pop);
  assign w_entry = '{err: w_fault, pc: r_pc, inst: (w_fault ? 32'h0 : IR)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Flush sources in priority order; a faulting fetch parks the PC so the
  // fault entry reports the offending address and nothing follows it.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    if (exc_req) begin
      w_pc_nxt    = EXC_VECTOR;
      w_state_nxt = ST_RUN;
    end else if (eret_req) begin
      w_pc_nxt    = epc;
      w_state_nxt = ST_RUN;
    end else if (redirect_valid) begin
      w_pc_nxt    = redirect_pc;
      w_state_nxt = ST_RUN;
    end else if (w_push) begin
      if (w_fault) w_state_nxt = ST_FAULT;
      else         w_pc_nxt    = r_pc + 32'd4;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_head  (w_head)
  );

  assign inst_valid = w_valid;
  assign inst_out   = w_head.inst;
  assign pc_out     = w_head.pc;
  assign fetch_err  = w_head.err;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] EXCV  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IM_addr, IR, redirect_pc, epc, inst_out, pc_out;
  logic        redirect_valid = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
  logic        inst_valid, inst_ready = 1'b0, fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          err;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_fault;

  always #5 clk = ~clk;

  // Instruction ROM contents: an arbitrary scramble of the word address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign IR = rom(IM_addr);

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h5000);
  endfunction

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .IM_addr(IM_addr), .IR(IR),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .pc_out(pc_out), .fetch_err(fetch_err)
  );

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h3000;
    m_fault = 0;
  endtask

  // Advance the reference by one clock using the inputs about to be sampled.
  task automatic model_step(input bit rdy, input bit redir, input logic [31:0] rpc,
                            input bit exc, input bit eret, input logic [31:0] ep);
    int   sz = mq.size();
    bit   pop = (sz > 0) && rdy;
    ent_t d;
    if (exc || eret || redir) begin
      mq.delete();
      m_fault = 0;
      m_pc = exc ? EXCV : (eret ? ep : rpc);
    end else begin
      if (pop) d = mq.pop_front();
      if (!m_fault && (sz < DEPTH || pop)) begin
        if (bad_addr(m_pc)) begin
          mq.push_back('{1'b1, m_pc, 32'h0});
          m_fault = 1;
        end else begin
          mq.push_back('{1'b0, m_pc, rom(m_pc)});
          m_pc = m_pc + 4;
        end
      end
    end
  endtask

  // Drive inputs, step the model, and land 1 time unit after the edge.
  task automatic tick(input bit rdy, input bit redir, input logic [31:0] rpc,
                      input bit exc, input bit eret, input logic [31:0] ep);
    inst_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    exc_req = exc; eret_req = eret; epc = ep;
    model_step(rdy, redir, rpc, exc, eret, ep);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_ready = 0; redirect_valid = 0; exc_req = 0; eret_req = 0;
    redirect_pc = 0; epc = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    n_tests++; if (IM_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_addr got %h exp 00003000", IM_addr); end
    n_tests++; if ({inst_out, pc_out, fetch_err} !== 65'h0) begin n_fail++; $display("FAIL reset_head got %h %h %b exp zeros", inst_out, pc_out, fetch_err); end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b1 || pc_out !== 32'h3000 + 4*(i-1) || inst_out !== rom(32'h3000 + 4*(i-1))) begin
        n_fail++; $display("FAIL stream_head%0d got v=%b pc=%h ir=%h exp pc=%h ir=%h", i, inst_valid, pc_out, inst_out, 32'h3000 + 4*(i-1), rom(32'h3000 + 4*(i-1)));
      end
      n_tests++;
      if (IM_addr !== 32'h3000 + 4*i) begin n_fail++; $display("FAIL stream_addr%0d got %h exp %h", i, IM_addr, 32'h3000 + 4*i); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 0);
    n_tests++; if (IM_addr !== 32'h3008 || mq.size() != 2) begin n_fail++; $display("FAIL bp_hold got addr=%h exp 00003008", IM_addr); end
    n_tests++; if (inst_valid !== 1'b1 || pc_out !== 32'h3000) begin n_fail++; $display("FAIL bp_head0 got v=%b pc=%h exp 1 00003000", inst_valid, pc_out); end
    for (int i = 1; i <= 3; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b1 || pc_out !== 32'h3000 + 4*i || inst_out !== rom(32'h3000 + 4*i)) begin
        n_fail++; $display("FAIL bp_head%0d got v=%b pc=%h exp pc=%h", i, inst_valid, pc_out, 32'h3000 + 4*i);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 32'h3100, 0, 0, 0);
    n_tests++; if (inst_valid !== 1'b0 || IM_addr !== 32'h3100) begin n_fail++; $display("FAIL redir_bubble got v=%b addr=%h exp 0 00003100", inst_valid, IM_addr); end
    tick(1, 0, 0, 0, 0, 0);
    n_tests++;
    if (inst_valid !== 1'b1 || pc_out !== 32'h3100 || inst_out !== rom(32'h3100) || fetch_err !== 1'b0) begin
      n_fail++; $display("FAIL redir_head got v=%b pc=%h ir=%h exp 1 00003100 %h", inst_valid, pc_out, inst_out, rom(32'h3100));
    end
  endtask

  task automatic test_priority();
    do_reset();
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 32'h3100, 1, 1, 32'h3020);
    n_tests++; if (IM_addr !== 32'h4180 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL prio_exc got addr=%h v=%b exp 00004180 0", IM_addr, inst_valid); end
    tick(1, 0, 0, 0, 1, 32'h3020);
    n_tests++; if (IM_addr !== 32'h3020) begin n_fail++; $display("FAIL prio_eret got %h exp 00003020", IM_addr); end
    tick(1, 0, 0, 0, 0, 0);
    n_tests++; if (inst_valid !== 1'b1 || pc_out !== 32'h3020) begin n_fail++; $display("FAIL eret_head got v=%b pc=%h exp 1 00003020", inst_valid, pc_out); end
  endtask

  task automatic test_fault();
    logic [31:0] tgt [3] = '{32'h3002, 32'h5000, 32'h2FFC};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, tgt[k], 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b1 || pc_out !== tgt[k] || inst_out !== 32'h0 || fetch_err !== 1'b1) begin
        n_fail++; $display("FAIL fault_head%0d got v=%b pc=%h ir=%h e=%b exp 1 %h 0 1", k, inst_valid, pc_out, inst_out, fetch_err, tgt[k]);
      end
      for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 0, 0);
      n_tests++; if (IM_addr !== tgt[k] || mq.size() != 1) begin n_fail++; $display("FAIL fault_park%0d got addr=%h exp %h", k, IM_addr, tgt[k]); end
      tick(1, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0);
      n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fault_nopush%0d got v=%b exp 0", k, inst_valid); end
      tick(1, 0, 0, 1, 0, 0);
      tick(1, 0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b1 || pc_out !== EXCV || fetch_err !== 1'b0 || inst_out !== rom(EXCV)) begin
        n_fail++; $display("FAIL fault_exc%0d got v=%b pc=%h e=%b exp 1 00004180 0", k, inst_valid, pc_out, fetch_err);
      end
    end
    // Last legal word, then the next sequential fetch crosses TEXT_HI.
    tick(1, 1, 32'h4FFC, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    n_tests++; if (inst_valid !== 1'b1 || pc_out !== 32'h4FFC || fetch_err !== 1'b0) begin n_fail++; $display("FAIL edge_ok got v=%b pc=%h e=%b exp 1 00004ffc 0", inst_valid, pc_out, fetch_err); end
    tick(1, 0, 0, 0, 0, 0);
    n_tests++; if (inst_valid !== 1'b1 || pc_out !== 32'h5000 || fetch_err !== 1'b1) begin n_fail++; $display("FAIL edge_fault got v=%b pc=%h e=%b exp 1 00005000 1", inst_valid, pc_out, fetch_err); end
  endtask

  function automatic logic [31:0] rand_target();
    int r = $urandom_range(0, 9);
    if (r == 0) return 32'h3000 + ($urandom_range(0, 32'h1FFF) | 32'h1);
    if (r == 1) return ($urandom_range(0, 1) != 0) ? 32'h5000 + 4*$urandom_range(0, 255) : 32'h2F00 + 4*$urandom_range(0, 63);
    if (r == 2) return 32'h4FF8;
    return 32'h3000 + 4*$urandom_range(0, 32'h7FF);
  endfunction

  task automatic test_random();
    bit ev;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rand_target(),
           $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0, rand_target());
      ev = (mq.size() > 0);
      n_tests++;
      if (inst_valid !== ev || IM_addr !== m_pc) begin
        n_fail++; $display("FAIL rand_ctl c=%0d got v=%b addr=%h exp v=%b addr=%h", c, inst_valid, IM_addr, ev, m_pc);
      end
      if (ev) begin
        n_tests++;
        if (pc_out !== mq[0].pc || inst_out !== mq[0].inst || fetch_err !== mq[0].err) begin
          n_fail++; $display("FAIL rand_head c=%0d got %h %h %b exp %h %h %b", c, pc_out, inst_out, fetch_err, mq[0].pc, mq[0].inst, mq[0].err);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (inst_valid !== 1'b0 || IM_addr !== 32'h3000) begin n_fail++; $display("FAIL async_reset got v=%b addr=%h exp 0 00003000", inst_valid, IM_addr); end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    tick(1, 0, 0, 0, 0, 0);
    n_tests++; if (inst_valid !== 1'b1 || pc_out !== 32'h3000) begin n_fail++; $display("FAIL async_restart got v=%b pc=%h exp 1 00003000", inst_valid, pc_out); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_priority();
    test_fault();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the instruction ROM. Holds the PC, drives `IM_addr` and samples the combinational `IR` return in the same cycle.
- Buffers fetched {pc, instruction} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, exception entry to the handler vector, ERET return, and fetch-address faults.
- Sits between the PC/redirect logic of the pipeline and the instruction ROM.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- TEXT_HI, 32'h0000_5000, highest legal fetch address (exclusive).
- DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IM_addr  out  32  fetch address to instruction ROM; equals current PC.
- IR  in  32  ROM read data, combinational from IM_addr, valid in the same cycle.
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  redirect target.
- exc_req  in  1  exception taken; load EXC_VECTOR.
- eret_req  in  1  return from exception; load epc.
- epc  in  32  ERET target.
- inst_valid  out  1  buffer head is valid.
- inst_ready  in  1  decode accepts head this cycle.
- inst_out  out  32  head instruction.
- pc_out  out  32  head PC.
- fetch_err  out  1  head entry is a fetch fault (AdEL); inst_out is 0 (nop).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, FIFO empty, occupancy count=0, state=RUN. inst_valid=0, inst_out=0, pc_out=0, fetch_err=0. IM_addr=RESET_PC.
- IM_addr = pc at all times (combinational).
- Pop: occurs when inst_valid && inst_ready.
- Push condition: state==RUN && no flush && (count<DEPTH || pop). Push and pop in the same cycle are legal when full; count is unchanged.
- Normal push: writes {pc, IR, err=0} and sets pc<=pc+4 (32-bit wrap, no saturation).
- Latency: an address presented in cycle N appears at the FIFO head in cycle N+1 if the FIFO was empty.
- Fault: if pc[1:0]!=0, pc<TEXT_LO, or pc>=TEXT_HI, the push writes {pc, 32'h0, err=1}. pc does not advance; state goes to FAULT.
  - FAULT: no pushes. Exit only via flush. An undelivered fault entry stays in the FIFO until popped.
- Flush events, priority exc_req > eret_req > redirect_valid:
  - Empty the FIFO, count<=0, and discard any push in the same cycle. A pop in the same cycle is also discarded; decode must not rely on it.
  - pc <= EXC_VECTOR / epc / redirect_pc respectively; state<=RUN.
  - inst_valid is 0 in the cycle after a flush. The first new entry appears one cycle after that (2-cycle redirect bubble).
- A misaligned redirect target is not rejected at load. It faults on its fetch per the fault rule above.
- Head outputs are driven from the FIFO head slot. inst_out, pc_out and fetch_err are don't-care when inst_valid=0 but must not be X after reset.
- FIFO: circular read/write pointers of log2(DEPTH) bits plus count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset mid-operation: immediate return to reset state regardless of pending flush or handshake.

Decomposition:
- Shared package `mips_defs`: RESET_PC, EXC_VECTOR, TEXT_LO/TEXT_HI constants, 32-bit word width, fetch-state encoding (RUN=0, FAULT=1).
- One sub-module: `fetch_fifo` (DEPTH-parameterised sync FIFO, entry = {err, pc[31:0], inst[31:0]}, with a flush input). PC, state and flush priority live in if_fetch_unit.

Test Plan:
- Reset/stream: release rst_n with ROM words 0x3000→A, 0x3004→B, 0x3008→C, inst_ready=1 → cycle 1 head {0x3000,A}, then {0x3004,B}, {0x3008,C} on consecutive cycles; IM_addr steps by 4.
- Backpressure: inst_ready=0 for 5 cycles, DEPTH=2 → count saturates at 2, IM_addr holds 0x3008. Set ready=1 → heads 0x3000, 0x3004, 0x3008 in order, none lost or duplicated.
- Redirect: redirect_valid with target 0x3100 while FIFO holds 2 entries → next cycle inst_valid=0, IM_addr=0x3100; following cycle head {0x3100, im[0x40]}.
- Priority: exc_req, eret_req (epc=0x3020) and redirect_valid (0x3100) asserted in the same cycle → pc=0x4180. Then eret_req alone → pc=0x3020.
- Fault: redirect to 0x3002 → head {0x3002, 0, fetch_err=1}, no further pushes for 10 cycles; exc_req → fetch resumes at 0x4180. Redirect to 0x5000 → fault likewise.
- Async reset: assert rst_n=0 mid-stream between clock edges with a full FIFO → inst_valid=0 and IM_addr=0x3000 immediately, before the next clock edge.
